// File: rtl/npu_defines.sv
// Shared types and sizing for the instruction-fetch path of the NPU.
// The bridge, its lane deserializer and the bench all take their lane geometry from here.
package npu_defines;

  localparam int LANE_BITS            = 512;
  localparam int BEAT_BITS            = 64;
  localparam int ADDR_BITS            = 32;
  localparam int BEATS                = LANE_BITS / BEAT_BITS;
  localparam int ICACHE_OFFSET_LENGTH = $clog2(LANE_BITS / 8);
  localparam int OFFSET_BITS          = ICACHE_OFFSET_LENGTH;
  localparam int CNT_BITS             = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [ADDR_BITS-1:0] address_t;
  typedef logic [LANE_BITS-1:0] icache_lane_t;
  typedef logic [BEAT_BITS-1:0] beat_t;
  typedef logic [CNT_BITS-1:0]  beat_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DELIVER
  } imb_state_t;

  // Refills are always whole lanes, so the byte offset within the lane is dropped.
  function automatic address_t line_align(input address_t addr);
    return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/instr_mem_bridge_lane_deserializer.sv
// Beat counter plus lane register: packs narrow memory beats into one icache lane, beat 0 in the LSBs.
// The lane is never cleared between refills so the delivered data stays visible until the next first beat.
module instr_lane_deserializer
  import npu_defines::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic         beat_valid,
  input  beat_t        beat_data,
  output icache_lane_t lane,
  output logic         last_beat,
  output beat_cnt_t    count
);

  beat_cnt_t    count_q, count_d;
  icache_lane_t lane_q, lane_d;

  assign last_beat = (count_q == beat_cnt_t'(BEATS - 1));
  assign lane      = lane_q;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    lane_d  = lane_q;
    if (enable) begin
      if (clear) begin
        count_d = '0;
      end else if (beat_valid) begin
        lane_d[count_q*BEAT_BITS +: BEAT_BITS] = beat_data;
        count_d = last_beat ? '0 : count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      lane_q  <= '0;
    end else begin
      count_q <= count_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/instr_mem_bridge.sv
// Memory-side icache refill bridge: one line-aligned request at a time, beats assembled into a lane,
// lane returned with a one-cycle valid pulse. Protocol slips are absorbed and recorded in a sticky flag.
module instr_mem_bridge
  import npu_defines::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         tc_instr_request_valid,
  input  address_t     tc_instr_request_address,
  output logic         mem_instr_request_available,
  output logic         mem_instr_request_valid,
  output icache_lane_t mem_instr_request_data_in,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output address_t     mem_req_address,
  input  logic         mem_rsp_valid,
  input  beat_t        mem_rsp_data,
  input  logic         mem_rsp_last,
  output logic         imb_protocol_error
);

  imb_state_t state_q, state_d;
  address_t   addr_q, addr_d;
  logic       err_q, err_d;
  logic       avail_q, req_valid_q, pulse_q;

  logic       des_clear;
  logic       des_beat_valid;
  logic       des_last_beat;
  beat_cnt_t  des_count;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    err_d          = err_q;
    des_clear      = 1'b0;
    des_beat_valid = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (tc_instr_request_valid) begin
            addr_d  = line_align(tc_instr_request_address);
            state_d = REQ;
          end
          if (mem_rsp_valid) err_d = 1'b1;
        end
        REQ: begin
          if (mem_req_ready) begin
            des_clear = 1'b1;
            state_d   = COLLECT;
          end
          if (mem_rsp_valid || tc_instr_request_valid) err_d = 1'b1;
        end
        COLLECT: begin
          if (mem_rsp_valid) begin
            des_beat_valid = 1'b1;
            if (des_last_beat) state_d = DELIVER;
            // The counter, not the last marker, decides completion; a disagreement is only recorded.
            if (mem_rsp_last && des_count != beat_cnt_t'(BEATS - 1)) err_d = 1'b1;
            if (!mem_rsp_last && des_last_beat) err_d = 1'b1;
          end
          if (tc_instr_request_valid) err_d = 1'b1;
        end
        DELIVER: begin
          state_d = IDLE;
          if (mem_rsp_valid || tc_instr_request_valid) err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      err_q       <= 1'b0;
      avail_q     <= 1'b1;
      req_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      avail_q     <= (state_d == IDLE);
      req_valid_q <= (state_d == REQ);
      pulse_q     <= (state_d == DELIVER);
    end
  end

  instr_lane_deserializer u_deser (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (des_clear),
    .beat_valid (des_beat_valid),
    .beat_data  (mem_rsp_data),
    .lane       (mem_instr_request_data_in),
    .last_beat  (des_last_beat),
    .count      (des_count)
  );

  assign mem_instr_request_available = avail_q;
  assign mem_instr_request_valid     = pulse_q;
  assign mem_req_valid               = req_valid_q;
  assign mem_req_address             = addr_q;
  assign imb_protocol_error          = err_q;

endmodule

// File: tb/tb_instr_mem_bridge.sv
// Bench for instr_mem_bridge: scenario tasks driving random lanes against a lane/address/error model.
module tb_instr_mem_bridge;
  import npu_defines::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         tc_valid;
  address_t     tc_addr;
  logic         avail;
  logic         pulse;
  icache_lane_t lane_out;
  logic         mreq_valid;
  logic         mreq_ready;
  address_t     mreq_addr;
  logic         rsp_valid;
  beat_t        rsp_data;
  logic         rsp_last;
  logic         perr;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic model_err;

  always #5 clk = ~clk;

  instr_mem_bridge dut (
    .clk                         (clk),
    .reset                       (reset),
    .enable                      (enable),
    .tc_instr_request_valid      (tc_valid),
    .tc_instr_request_address    (tc_addr),
    .mem_instr_request_available (avail),
    .mem_instr_request_valid     (pulse),
    .mem_instr_request_data_in   (lane_out),
    .mem_req_valid               (mreq_valid),
    .mem_req_ready               (mreq_ready),
    .mem_req_address             (mreq_addr),
    .mem_rsp_valid               (rsp_valid),
    .mem_rsp_data                (rsp_data),
    .mem_rsp_last                (rsp_last),
    .imb_protocol_error          (perr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable     = 1'b1;
    tc_valid   = 1'b0;
    tc_addr    = '0;
    mreq_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_err = 1'b0;
    step();
  endtask

  function automatic address_t model_align(input address_t a);
    return (a / address_t'(LANE_BITS / 8)) * address_t'(LANE_BITS / 8);
  endfunction

  // Full refill: request, ready after ready_dly cycles, beats with gap idle cycles between them.
  task automatic run_refill(input address_t addr, input int ready_dly, input int gap,
                            input int early_idx, input bit last_on_final,
                            input int overlap_idx, input bit seq_data, input string tag);
    beat_t        beats [BEATS];
    icache_lane_t exp_lane;
    address_t     exp_addr;
    bit           stable;
    bit           no_rereq;
    exp_addr = model_align(addr);
    exp_lane = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      beats[i] = seq_data ? beat_t'(i) : {$urandom, $urandom};
      exp_lane = (exp_lane << BEAT_BITS) | icache_lane_t'(beats[i]);
    end
    if ((early_idx >= 0 && early_idx < BEATS - 1) || !last_on_final || overlap_idx >= 0)
      model_err = 1'b1;

    tc_addr  = addr;
    tc_valid = 1'b1;
    step();
    tc_valid = 1'b0;
    tc_addr  = $urandom;
    n_checks++;
    if (mreq_valid !== 1'b1 || avail !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req_issue: mem_req_valid=%b available=%b, want 1 and 0", tag, mreq_valid, avail);
    end
    n_checks++;
    if (mreq_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL %s req_addr: got %h want %h", tag, mreq_addr, exp_addr);
    end
    stable = 1'b1;
    for (int c = 0; c < ready_dly; c++) begin
      step();
      if (mreq_valid !== 1'b1 || mreq_addr !== exp_addr) stable = 1'b0;
    end
    if (ready_dly > 0) begin
      n_checks++;
      if (!stable) begin
        n_fail++;
        $display("FAIL %s req_hold: mem_req_valid=%b addr=%h, want 1 and %h", tag, mreq_valid, mreq_addr, exp_addr);
      end
    end
    mreq_ready = 1'b1;
    step();
    mreq_ready = 1'b0;
    n_checks++;
    if (mreq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req_drop: mem_req_valid=%b want 0 after ready", tag, mreq_valid);
    end

    for (int i = 0; i < BEATS; i++) begin
      if (i > 0) repeat (gap) step();
      rsp_valid = 1'b1;
      rsp_data  = beats[i];
      rsp_last  = (i == early_idx) || (i == BEATS - 1 && last_on_final);
      tc_valid  = (i == overlap_idx);
      step();
      rsp_valid = 1'b0;
      rsp_last  = 1'b0;
      tc_valid  = 1'b0;
      rsp_data  = $urandom;
      if (i < BEATS - 1 && pulse !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s early_pulse: valid=1 after beat %0d", tag, i);
      end
    end

    n_checks++;
    if (pulse !== 1'b1 || avail !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse: valid=%b available=%b, want 1 and 0", tag, pulse, avail);
    end
    n_checks++;
    if (lane_out !== exp_lane) begin
      n_fail++;
      $display("FAIL %s lane: got %h want %h", tag, lane_out, exp_lane);
    end
    step();
    n_checks++;
    if (pulse !== 1'b0 || avail !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_pulse: valid=%b available=%b, want 0 and 1", tag, pulse, avail);
    end
    no_rereq = 1'b1;
    repeat (2) begin
      step();
      if (mreq_valid !== 1'b0 || pulse !== 1'b0) no_rereq = 1'b0;
    end
    n_checks++;
    if (!no_rereq || lane_out !== exp_lane) begin
      n_fail++;
      $display("FAIL %s idle_hold: mem_req_valid=%b valid=%b lane_ok=%b, want 0 0 1",
               tag, mreq_valid, pulse, lane_out === exp_lane);
    end
    n_checks++;
    if (perr !== model_err) begin
      n_fail++;
      $display("FAIL %s err_flag: got %b want %b", tag, perr, model_err);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_checks++;
    if (avail !== 1'b1 || pulse !== 1'b0 || mreq_valid !== 1'b0 || perr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: avail=%b valid=%b req=%b err=%b, want 1 0 0 0", avail, pulse, mreq_valid, perr);
    end
    n_checks++;
    if (mreq_addr !== '0 || lane_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h lane=%h, want zeros", mreq_addr, lane_out);
    end
    step();
    reset = 1'b0;
    model_err = 1'b0;
    step();
  endtask

  task automatic test_single_refill();
    apply_reset();
    run_refill(32'h0000_1234, 0, 0, -1, 1'b1, -1, 1'b1, "single");
  endtask

  task automatic test_backpressure();
    apply_reset();
    run_refill(address_t'($urandom), 5, 2, -1, 1'b1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_early_last();
    apply_reset();
    run_refill(address_t'($urandom), 1, 0, 3, 1'b0, -1, 1'b0, "early_last");
  endtask

  task automatic test_stray_and_overlap();
    apply_reset();
    rsp_valid = 1'b1;
    rsp_data  = {$urandom, $urandom};
    step();
    rsp_valid = 1'b0;
    model_err = 1'b1;
    n_checks++;
    if (perr !== 1'b1 || avail !== 1'b1 || mreq_valid !== 1'b0 || lane_out !== '0) begin
      n_fail++;
      $display("FAIL stray_idle: err=%b avail=%b req=%b lane_zero=%b, want 1 1 0 1",
               perr, avail, mreq_valid, lane_out === '0);
    end
    run_refill(address_t'($urandom), 2, 1, -1, 1'b1, 3, 1'b0, "overlap");
  endtask

  task automatic test_enable_stall();
    icache_lane_t exp_lane;
    address_t     addr;
    bit           held;
    int           pulse_len;
    apply_reset();
    addr     = $urandom;
    tc_addr  = addr;
    tc_valid = 1'b1;
    step();
    tc_valid   = 1'b0;
    enable     = 1'b0;
    mreq_ready = 1'b1;
    held = 1'b1;
    repeat (3) begin
      step();
      if (mreq_valid !== 1'b1 || mreq_addr !== model_align(addr)) held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL stall_req: mem_req_valid=%b addr=%h, want 1 and %h", mreq_valid, mreq_addr, model_align(addr));
    end
    enable = 1'b1;
    step();
    mreq_ready = 1'b0;
    exp_lane = '0;
    for (int i = 0; i < BEATS; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = {$urandom, $urandom};
      rsp_last  = (i == BEATS - 1);
      exp_lane[i*BEAT_BITS +: BEAT_BITS] = rsp_data;
      step();
    end
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    enable    = 1'b0;
    pulse_len = 0;
    for (int c = 0; c < 6; c++) begin
      if (pulse === 1'b1) pulse_len++;
      step();
      if (c == 2) enable = 1'b1;
    end
    n_checks++;
    if (pulse_len != 4) begin
      n_fail++;
      $display("FAIL stall_pulse: valid lasted %0d cycles, want 4", pulse_len);
    end
    n_checks++;
    if (lane_out !== exp_lane || avail !== 1'b1 || perr !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_lane: lane_ok=%b avail=%b err=%b, want 1 1 0", lane_out === exp_lane, avail, perr);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tc_addr  = $urandom;
    tc_valid = 1'b1;
    step();
    tc_valid   = 1'b0;
    mreq_ready = 1'b1;
    step();
    mreq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rsp_valid = 1'b1;
      rsp_data  = {$urandom, $urandom};
      step();
    end
    rsp_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (avail !== 1'b1 || pulse !== 1'b0 || mreq_valid !== 1'b0 || perr !== 1'b0 ||
        mreq_addr !== '0 || lane_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: avail=%b valid=%b req=%b err=%b addr=%h lane_zero=%b",
               avail, pulse, mreq_valid, perr, mreq_addr, lane_out === '0);
    end
    step();
    reset = 1'b0;
    model_err = 1'b0;
    step();
    rsp_valid = 1'b1;
    rsp_data  = {$urandom, $urandom};
    step();
    rsp_valid = 1'b0;
    model_err = 1'b1;
    run_refill(address_t'($urandom), 0, 0, -1, 1'b1, -1, 1'b0, "after_reset");
  endtask

  task automatic test_random_refills();
    apply_reset();
    for (int n = 0; n < 6; n++)
      run_refill(address_t'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                 -1, 1'b1, -1, 1'b0, "random");
  endtask

  initial begin
    reset     = 1'b0;
    model_err = 1'b0;
    idle_inputs();
    test_reset();
    test_single_refill();
    test_backpressure();
    test_early_last();
    test_stray_and_overlap();
    test_enable_stall();
    test_reset_mid();
    test_random_refills();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
